// File: rtl/bch_eras_syndrome_count_par_if.sv
// Stream/RAM/syndrome bundle for bch_eras_syndrome_count_par.
// master drives the code stream; slave is the syndrome counter.
interface bch_eras_syndrome_count_par_if #(
    parameter int unsigned m     = 4,
    parameter int unsigned DAT_W = 4,
    parameter int unsigned PTR_W = 1,
    parameter int unsigned T2    = 6,
    parameter int unsigned AW    = 2,
    parameter int unsigned CW    = 3
);
    logic                          isop;
    logic                          ival;
    logic                          ieop;
    logic [DAT_W-1:0]              idat;
    logic [DAT_W-1:0]              ieras;
    logic [AW-1:0]                 oram_addr;
    logic [PTR_W-1:0]              oram_ptr;
    logic [DAT_W-1:0]              oram_data;
    logic [DAT_W-1:0]              oram_eras;
    logic                          oram_write;
    logic                          osyndrome_val;
    logic [PTR_W-1:0]              osyndrome_ptr;
    // [set][i-1][bit]: set 0 = erasures as 0, set 1 = erasures as 1
    logic [1:0][T2-1:0][m-1:0]     osyndrome;
    logic [CW-1:0]                 oeras_num;
    logic                          oeras_ovf;
    logic                          oframe_err;

    modport master (
        output isop, ival, ieop, idat, ieras,
        input  oram_addr, oram_ptr, oram_data, oram_eras, oram_write,
        input  osyndrome_val, osyndrome_ptr, osyndrome, oeras_num, oeras_ovf, oframe_err
    );

    modport slave (
        input  isop, ival, ieop, idat, ieras,
        output oram_addr, oram_ptr, oram_data, oram_eras, oram_write,
        output osyndrome_val, osyndrome_ptr, osyndrome, oeras_num, oeras_ovf, oframe_err
    );
endinterface

// File: rtl/bch_eras_syndrome_count_par.sv
// Parallel BCH erasure syndrome counter: DAT_W bits/cycle, two syndrome sets, ping-pong RAM feed.
// Optional frame length checker enabled by defining BCH_ERAS_FRAME_CHECK_EN.
module bch_eras_syndrome_count_par #(
    parameter int unsigned m      = 4,
    parameter int unsigned n      = 15,
    parameter int unsigned d      = 7,
    parameter int unsigned irrpol = 19,
    parameter int unsigned DAT_W  = 4,
    parameter int unsigned PTR_W  = 1
) (
    input  logic                           iclk,
    input  logic                           ireset_n,
    input  logic                           iclkena,
    bch_eras_syndrome_count_par_if.slave   bus_io
);
    localparam int unsigned T2  = d - 1;
    localparam int unsigned NW  = (n + DAT_W - 1) / DAT_W;
    localparam int unsigned AW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned CW  = $clog2(T2 + 1);
    localparam int unsigned REM = n % DAT_W;
    localparam int unsigned ORD = (1 << m) - 1;
    localparam logic [m:0]  POLY = (m + 1)'(irrpol);
    // Leading bits of the first word lie above degree n-1
    localparam logic [DAT_W-1:0] PAD_MASK = (REM == 0) ? {DAT_W{1'b1}} : DAT_W'((1 << REM) - 1);

    function automatic logic [m-1:0] gf_mul(input logic [m-1:0] a, input logic [m-1:0] b);
        logic [m:0] r;
        r = '0;
        for (int k = m - 1; k >= 0; k--) begin
            r = {r[m-1:0], 1'b0};
            if (r[m]) r = r ^ POLY;
            if (b[k]) r = r ^ {1'b0, a};
        end
        return r[m-1:0];
    endfunction

    // Fixed loop bound keeps this a constant fold for every call site
    function automatic logic [m-1:0] gf_pow(input int unsigned e);
        logic [m-1:0] r;
        r = m'(1);
        for (int unsigned t = 0; t < ORD; t++)
            if (t < e % ORD) r = gf_mul(r, m'(2));
        return r;
    endfunction

    logic [1:0][T2-1:0][m-1:0] syn_q, syn_d;
    logic [CW-1:0]             cnt_q, cnt_base, cnt_d;
    logic                      ovf_q, ovf_d, ovf_hit;
    logic [AW-1:0]             addr_q;
    logic [PTR_W-1:0]          ptr_q;
    logic [DAT_W-1:0]          data_q, eras_q;
    logic                      write_q, sval_q;
    logic [DAT_W-1:0]          dat_m, eras_m, acc, bsel;
    logic [m-1:0]              term;
    int unsigned               req, tot;

    always_comb begin
        dat_m    = bus_io.idat & (bus_io.isop ? PAD_MASK : {DAT_W{1'b1}});
        eras_m   = bus_io.ieras & (bus_io.isop ? PAD_MASK : {DAT_W{1'b1}});
        cnt_base = bus_io.isop ? '0 : cnt_q;
        acc      = '0;
        ovf_hit  = 1'b0;
        req      = 0;
        // Requested (not accepted) flags above j decide acceptance of bit j
        for (int j = DAT_W - 1; j >= 0; j--) begin
            if (eras_m[j]) begin
                if (32'(cnt_base) + req < T2) acc[j] = 1'b1;
                else                          ovf_hit = 1'b1;
                req = req + 1;
            end
        end
        tot   = 32'(cnt_base) + req;
        cnt_d = (tot > T2) ? CW'(T2) : CW'(tot);
        ovf_d = (bus_io.isop ? 1'b0 : ovf_q) | ovf_hit;
    end

    always_comb begin
        syn_d = '0;
        bsel  = '0;
        term  = '0;
        for (int s = 0; s < 2; s++) begin
            bsel = (s == 1) ? (dat_m | acc) : (dat_m & ~acc);
            for (int i = 1; i <= int'(T2); i++) begin
                term = bus_io.isop ? '0 : gf_mul(syn_q[s][i-1], gf_pow(i * DAT_W));
                for (int j = 0; j < int'(DAT_W); j++)
                    if (bsel[j]) term = term ^ gf_pow(i * j);
                syn_d[s][i-1] = term;
            end
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            write_q <= 1'b0;
            sval_q  <= 1'b0;
            ptr_q   <= '0;
        end else if (iclkena) begin
            write_q <= bus_io.ival;
            sval_q  <= bus_io.ival & bus_io.ieop;
            if (bus_io.ival && bus_io.isop) ptr_q <= ptr_q + PTR_W'(1);
        end
    end

    // Datapath registers are deliberately left without reset
    always_ff @(posedge iclk) begin
        if (iclkena && bus_io.ival) begin
            syn_q  <= syn_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            addr_q <= bus_io.isop ? '0 : addr_q + AW'(1);
            data_q <= dat_m;
            eras_q <= acc;
        end
    end

`ifdef BCH_ERAS_FRAME_CHECK_EN
    localparam int unsigned WW = $clog2(NW + 1);
    logic [WW-1:0] widx_q, widx;
    logic          bad, err_q;

    always_comb begin
        if (bus_io.isop)               widx = '0;
        else if (32'(widx_q) >= NW)    widx = WW'(NW);
        else                           widx = widx_q + WW'(1);
        bad = bus_io.ieop ? (32'(widx) != NW - 1) : (32'(widx) >= NW);
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            widx_q <= '0;
            err_q  <= 1'b0;
        end else if (iclkena && bus_io.ival) begin
            widx_q <= widx;
            err_q  <= (bus_io.isop ? 1'b0 : err_q) | bad;
        end
    end

    assign bus_io.oframe_err = err_q;
`else
    assign bus_io.oframe_err = 1'b0;
`endif

    assign bus_io.oram_addr     = addr_q;
    assign bus_io.oram_ptr      = ptr_q;
    assign bus_io.oram_data     = data_q;
    assign bus_io.oram_eras     = eras_q;
    assign bus_io.oram_write    = write_q;
    assign bus_io.osyndrome_val = sval_q;
    assign bus_io.osyndrome_ptr = ptr_q;
    assign bus_io.osyndrome     = syn_q;
    assign bus_io.oeras_num     = cnt_q;
    assign bus_io.oeras_ovf     = ovf_q;
endmodule

// File: tb/tb_bch_eras_syndrome_count_par.sv
// Scoreboard bench for bch_eras_syndrome_count_par (m=4, n=15, d=7, DAT_W=4, PTR_W=1).
// Syndrome hex packs S[6]..S[1], one nibble each; alpha powers of x^4+x+1 worked by hand.
module tb_bch_eras_syndrome_count_par;
    localparam int M = 4, DW = 4, PW = 1, T2 = 6, AW = 2, CW = 3;
`ifdef BCH_ERAS_FRAME_CHECK_EN
    localparam logic ERR_SHORT = 1'b1;
`else
    localparam logic ERR_SHORT = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] s0;
        logic [23:0] s1;
        logic [2:0]  num;
        logic        ovf;
        logic        err;
        logic        ptr;
    } syn_t;

    typedef struct packed {
        logic [1:0] addr;
        logic       ptr;
        logic [3:0] dat;
        logic [3:0] eras;
    } ram_t;

    logic iclk = 1'b0;
    logic ireset_n = 1'b0;
    logic iclkena = 1'b0;
    syn_t syn_q[$];
    ram_t ram_q[$];
    syn_t se;
    ram_t re;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [1:0] addr_m = '0;
    logic       ptr_m = 1'b0;

    always #5 iclk = ~iclk;

    bch_eras_syndrome_count_par_if #(
        .m(M), .DAT_W(DW), .PTR_W(PW), .T2(T2), .AW(AW), .CW(CW)
    ) bus ();

    bch_eras_syndrome_count_par #(
        .m(4), .n(15), .d(7), .irrpol(19), .DAT_W(4), .PTR_W(1)
    ) dut (
        .iclk(iclk),
        .ireset_n(ireset_n),
        .iclkena(iclkena),
        .bus_io(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic word(input logic sop, input logic eop, input logic [3:0] dat,
                        input logic [3:0] eras, input logic [3:0] edat, input logic [3:0] eeras);
        ram_t x;
        if (sop) begin
            ptr_m  = ptr_m + 1'b1;
            addr_m = '0;
        end else begin
            addr_m = addr_m + 1'b1;
        end
        x.addr = addr_m;
        x.ptr  = ptr_m;
        x.dat  = edat;
        x.eras = eeras;
        ram_q.push_back(x);
        bus.isop = sop; bus.ieop = eop; bus.ival = 1'b1; bus.idat = dat; bus.ieras = eras;
        @(posedge iclk);
        #1;
        bus.isop = 1'b0; bus.ieop = 1'b0; bus.ival = 1'b0; bus.idat = '0; bus.ieras = '0;
    endtask

    task automatic expect_syn(input logic [23:0] s0, input logic [23:0] s1, input logic [2:0] num,
                              input logic ovf, input logic err);
        syn_t x;
        x.s0 = s0; x.s1 = s1; x.num = num; x.ovf = ovf; x.err = err; x.ptr = ptr_m;
        syn_q.push_back(x);
    endtask

    always @(negedge iclk) begin
        if (ireset_n) begin
            if (bus.oram_write) begin
                if (ram_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ram_write: got unexpected write, expected none (t=%0t)", $time);
                end else begin
                    re = ram_q.pop_front();
                    check("ram_addr", 64'(bus.oram_addr), 64'(re.addr));
                    check("ram_ptr",  64'(bus.oram_ptr),  64'(re.ptr));
                    check("ram_data", 64'(bus.oram_data), 64'(re.dat));
                    check("ram_eras", 64'(bus.oram_eras), 64'(re.eras));
                end
            end
            if (bus.osyndrome_val) begin
                if (syn_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL syn_val: got unexpected strobe, expected none (t=%0t)", $time);
                end else begin
                    se = syn_q.pop_front();
                    check("syn_set0", 64'(bus.osyndrome[0]), 64'(se.s0));
                    check("syn_set1", 64'(bus.osyndrome[1]), 64'(se.s1));
                    check("eras_num", 64'(bus.oeras_num),    64'(se.num));
                    check("eras_ovf", 64'(bus.oeras_ovf),    64'(se.ovf));
                    check("frame_err", 64'(bus.oframe_err),  64'(se.err));
                    check("syn_ptr",  64'(bus.osyndrome_ptr), 64'(se.ptr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.isop = 1'b0; bus.ieop = 1'b0; bus.ival = 1'b0; bus.idat = '0; bus.ieras = '0;
        iclkena = 1'b1;
        idle(3);
        check("rst_write", 64'(bus.oram_write), 64'd0);
        check("rst_ptr",   64'(bus.oram_ptr),   64'd0);
        check("rst_val",   64'(bus.osyndrome_val), 64'd0);
        check("rst_err",   64'(bus.oframe_err), 64'd0);
        ireset_n = 1'b1;
        idle(2);

        // All-zero frame, then single error at degree 0, back to back
        word(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        word(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        word(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'h111111, 24'h111111, 3'd0, 1'b0, 1'b0);
        word(0, 1, 4'h1, 4'h0, 4'h1, 4'h0);
        idle(2);

        // Erasure at degree 14, with a valid gap and a disabled-clock window of junk
        word(1, 0, 4'h0, 4'h4, 4'h0, 4'h4);
        idle(1);
        iclkena = 1'b0;
        bus.ival = 1'b1; bus.isop = 1'b1; bus.ieop = 1'b1; bus.idat = '1; bus.ieras = '1;
        idle(2);
        bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.idat = '0; bus.ieras = '0;
        iclkena = 1'b1;
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'h0, 24'hA7EFD9, 3'd1, 1'b0, 1'b0);
        word(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        check("val_latency", 64'(bus.osyndrome_val), 64'd1);
        idle(1);
        check("val_one_shot", 64'(bus.osyndrome_val), 64'd0);

        // Eight erasures over degrees 11..4: only degrees 11..6 accepted
        word(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'hF, 4'h0, 4'hF);
        word(0, 0, 4'h0, 4'hF, 4'h0, 4'hC);
        expect_syn(24'h0, 24'hC01811, 3'd6, 1'b1, 1'b0);
        word(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);

        // Padding bit carries data and erasure: both ignored
        word(1, 0, 4'h8, 4'h8, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        word(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset in the middle of a frame
        word(1, 0, 4'hF, 4'h3, 4'h7, 4'h3);
        word(0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
        idle(1);
        ireset_n = 1'b0;
        #1;
        check("midrst_write", 64'(bus.oram_write), 64'd0);
        check("midrst_ptr",   64'(bus.oram_ptr),   64'd0);
        check("midrst_val",   64'(bus.osyndrome_val), 64'd0);
        ptr_m = 1'b0;
        idle(2);
        ireset_n = 1'b1;
        idle(2);

        // Data at degree 11 plus erasure at degree 1; first frame after reset is page 1
        word(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h8, 4'h0, 4'h8, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'hC798BE, 24'h01A0FC, 3'd1, 1'b0, 1'b0);
        word(0, 1, 4'h0, 4'h2, 4'h0, 4'h2);

        // Short frame: ieop on word 2
        word(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'h0, 24'h0, 3'd0, 1'b0, ERR_SHORT);
        word(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);

        // Restart mid-frame: partial garbage must not leak into the reloaded frame
        word(1, 0, 4'hF, 4'h0, 4'h7, 4'h0);
        word(0, 0, 4'hF, 4'h0, 4'hF, 4'h0);
        word(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        word(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        expect_syn(24'h0, 24'h0, 3'd0, 1'b0, 1'b0);
        word(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);

        idle(4);
        check("syn_pending", 64'(syn_q.size()), 64'd0);
        check("ram_pending", 64'(ram_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
